// File: rtl/hdb3_rx_ctrl.sv
// hdb3_rx_ctrl: HDB3 code-rule checker, LOS/ACQ/LOCK link FSM and lock-gated byte packer.
module hdb3_rx_ctrl #(
  parameter int DEC_LAT    = 7,
  parameter int LOS_ZEROS  = 32,
  parameter int ACQ_PULSES = 16,
  parameter int ERR_WIN    = 256,
  parameter int ERR_THRESH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_hdb3_code,
  input  logic        i_dec_data,
  input  logic        i_ready,
  input  logic        i_err_clr,
  output logic [1:0]  o_state,
  output logic [7:0]  o_byte,
  output logic        o_valid,
  output logic [15:0] o_err_cnt,
  output logic        o_ovf
);
  localparam int PW = $clog2(ACQ_PULSES + 1);
  localparam int WW = $clog2(ERR_WIN);
  localparam int EW = $clog2(ERR_THRESH + 1);
  typedef enum logic [1:0] {LOS = 2'b00, ACQ = 2'b01, LOCK = 2'b10} state_t;
  state_t state, state_nx;
  logic [7:0] zrun;
  logic last_pol, have_pol, pulse_r, err_r;
  logic [PW-1:0] pcnt;
  logic [WW-1:0] wcnt;
  logic [EW-1:0] werr, werr_sum;
  logic [DEC_LAT-1:0] lock_sr;
  logic [6:0] shreg;
  logic [2:0] bcnt;
  logic pulse, err, los, wend, lock_d, full, load, drop;
  assign o_state = state;
  // A same-polarity pulse is only legal as a violation (gap 2 or 3); have_pol masks the first pulse
  always_comb begin
    pulse    = i_hdb3_code == 2'b01 || i_hdb3_code == 2'b10;
    err      = i_hdb3_code == 2'b11
            || (pulse && have_pol && i_hdb3_code[1] == last_pol && zrun != 8'd2 && zrun != 8'd3)
            || (i_hdb3_code == 2'b00 && zrun == 8'd3);
    los      = zrun == 8'(LOS_ZEROS);
    werr_sum = werr + EW'(err_r);
    wend     = wcnt == WW'(ERR_WIN - 1);
    lock_d   = lock_sr[DEC_LAT-1];
    full     = lock_d && bcnt == 3'd7;
    load     = full && (!o_valid || i_ready);
    drop     = full && o_valid && !i_ready;
  end
  always_comb begin
    state_nx = state;
    state_nx = los            ? LOS
             : state == LOS   ? (pulse_r ? ACQ : LOS)
             : state == ACQ   ? ((pulse_r && !err_r && pcnt == PW'(ACQ_PULSES - 1)) ? LOCK : ACQ)
             : state == LOCK  ? ((werr_sum == EW'(ERR_THRESH)) ? ACQ : LOCK)
             : LOS;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= LOS;
    else state <= state_nx;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zrun      <= 8'd0;
      last_pol  <= 1'b0;
      have_pol  <= 1'b0;
      pulse_r   <= 1'b0;
      err_r     <= 1'b0;
      o_err_cnt <= 16'd0;
      pcnt      <= '0;
      wcnt      <= '0;
      werr      <= '0;
    end else begin
      zrun      <= i_hdb3_code != 2'b00 ? 8'd0 : zrun == 8'hFF ? zrun : zrun + 8'd1;
      if (pulse) last_pol <= i_hdb3_code[1];
      have_pol  <= !los && (have_pol || pulse);
      pulse_r   <= pulse;
      err_r     <= err;
      o_err_cnt <= i_err_clr ? 16'd0 : o_err_cnt + 16'(err_r && o_err_cnt != 16'hFFFF);
      pcnt      <= (state != ACQ || state_nx != ACQ || err_r) ? '0 : pcnt + PW'(pulse_r);
      wcnt      <= (state != LOCK || state_nx != LOCK || wend) ? '0 : wcnt + WW'(1);
      werr      <= (state != LOCK || state_nx != LOCK || wend) ? '0 : werr_sum;
    end
  end
  // Lock is delayed to line up with the decoder output; losing it discards the partial byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_sr <= '0;
      shreg   <= 7'd0;
      bcnt    <= 3'd0;
      o_byte  <= 8'd0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      lock_sr <= DEC_LAT'({lock_sr, state == LOCK});
      shreg   <= lock_d ? {shreg[5:0], i_dec_data} : 7'd0;
      bcnt    <= lock_d ? bcnt + 3'd1 : 3'd0;
      if (load) o_byte <= {shreg, i_dec_data};
      o_valid <= load || (o_valid && !i_ready);
      o_ovf   <= !i_err_clr && (o_ovf || drop);
    end
  end
endmodule
